// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared declarations for the sequential shift-add multiplier:
//   - mult_state_t    : controller state encoding (IDLE, RUN, DONE)
//   - MULT_WIDTH_DEF  : default operand width
//   - cnt_width()     : width of the iteration counter, clog2(WIDTH+1)
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEF = 4;

    // The counter is loaded with WIDTH itself, so it needs room for WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : mult_pkg

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// Combinational single iteration of the shift-add multiplier.
// Ports:
//   acc        in   2*WIDTH  partial product
//   mplier     in   WIDTH    remaining multiplier bits (LSB is examined)
//   mcand      in   WIDTH    multiplicand
//   acc_nxt    out  2*WIDTH  partial product after conditional add + shift
//   mplier_nxt out  WIDTH    multiplier after shift
// ---------------------------------------------------------------------------
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // Upper half plus optional multiplicand; the carry bit is kept so the
    // right shift below brings it back into the accumulator's MSB.
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplier[0]) begin
            sum = sum + {1'b0, mcand};
        end
        // Shift {carry, acc_hi_sum, acc_lo, mplier} right by one.
        acc_nxt    = {sum, acc[WIDTH-1:1]};
        mplier_nxt = {acc[0], mplier[WIDTH-1:1]};
    end

endmodule : mult_step

// File: rtl/mult_seq_n.sv
// ---------------------------------------------------------------------------
// mult_seq_n
// Sequential shift-add multiplier, WIDTH iterations per product.
// Optional feature macro: MULT_SIGNED_EN (adds the tc port for two's
// complement operands; magnitudes are multiplied and the result negated).
// Ports:
//   clk        in   1        clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   start      in   1        request, sampled only while busy=0
//   a, b       in   WIDTH    operands, captured on the accepting edge
//   tc         in   1        two's complement operands (MULT_SIGNED_EN only)
//   busy       out  1        operation in progress
//   done       out  1        one-cycle pulse, z has just been updated
//   z          out  2*WIDTH  registered product, held between completions
//   state_dbg  out  2        current controller state (mult_state_t code)
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0 (IDLE or DONE). While busy=1, start is ignored and not queued.
// done is high for exactly the cycle following the final iteration edge.
// ---------------------------------------------------------------------------
module mult_seq_n
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic               tc,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z,
    output logic [1:0]         state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    mult_state_t        state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier_nxt;

    // Operand values to capture on the accepting edge.
    logic [WIDTH-1:0]   a_cap;
    logic [WIDTH-1:0]   b_cap;

`ifdef MULT_SIGNED_EN
    logic sign;
    logic sign_cap;

    // Magnitudes of signed operands; the most negative value negates to
    // itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        a_cap    = a;
        b_cap    = b;
        sign_cap = 1'b0;
        if (tc) begin
            a_cap    = a[WIDTH-1] ? -a : a;
            b_cap    = b[WIDTH-1] ? -b : b;
            sign_cap = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_cap = a;
        b_cap = b;
    end
`endif

    mult_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .acc        (acc),
        .mplier     (mplier),
        .mcand      (mcand),
        .acc_nxt    (acc_nxt),
        .mplier_nxt (mplier_nxt)
    );

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`ifdef MULT_SIGNED_EN
            sign   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE, which is what
                // gives one result every WIDTH+1 cycles with start held high.
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        mcand  <= a_cap;
                        mplier <= b_cap;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
`ifdef MULT_SIGNED_EN
                        sign   <= sign_cap;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Last iteration: publish this edge's result directly.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef MULT_SIGNED_EN
                        z     <= sign ? -acc_nxt : acc_nxt;
`else
                        z     <= acc_nxt;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : mult_seq_n

// File: tb/tb_mult_seq_n.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_n
// Self-checking bench for mult_seq_n (WIDTH=4). Expected products come from
// plain integer arithmetic; expected timing comes from the documented
// latency (done one cycle after the WIDTH-th iteration edge).
// ---------------------------------------------------------------------------
module tb_mult_seq_n;

    localparam int W = 4;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           tc;
    logic           busy;
    logic           done;
    logic [2*W-1:0] z;
    logic [1:0]     state_dbg;

    int total = 0;
    int bad   = 0;

    mult_seq_n #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef MULT_SIGNED_EN
        .tc        (tc),
`endif
        .busy      (busy),
        .done      (done),
        .z         (z),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: integer product, operands sign-interpreted when tc=1.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic t);
        longint xs;
        longint ys;
        longint p;
        xs = longint'(x);
        ys = longint'(y);
`ifdef MULT_SIGNED_EN
        if (t) begin
            if (x[W-1]) xs = xs - (longint'(1) << W);
            if (y[W-1]) ys = ys - (longint'(1) << W);
        end
`else
        if (t) begin
            xs = longint'(x);
        end
`endif
        p = xs * ys;
        return p[2*W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with the DUT idle; runs one full operation and
    // checks busy/done timing, the product and that z holds afterwards.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ti,
                          input string tag);
        logic [2*W-1:0] exp_z;
        exp_z = ref_mul(ai, bi, ti);
        a     = ai;
        b     = bi;
        tc    = ti;
        start = 1'b1;
        @(posedge clk); #1;          // accepting edge E0
        start = 1'b0;
        a     = $urandom_range(0, (1 << W) - 1);
        b     = $urandom_range(0, (1 << W) - 1);
        check({tag, "_busy_e0"}, 64'(busy), 64'(1));
        for (int k = 1; k < W; k++) begin
            @(posedge clk); #1;
            check({tag, "_busy_run"}, 64'(busy), 64'(1));
            check({tag, "_done_run"}, 64'(done), 64'(0));
        end
        @(posedge clk); #1;          // edge E_W
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_busy_done"}, 64'(busy), 64'(0));
        check({tag, "_z"}, 64'(z), 64'(exp_z));
        @(posedge clk); #1;
        check({tag, "_done_low"}, 64'(done), 64'(0));
        check({tag, "_z_hold"}, 64'(z), 64'(exp_z));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rt;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        tc      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_z", 64'(z), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Largest operands.
        run_op(4'hF, 4'hF, 1'b0, "max");
        repeat (3) begin
            @(posedge clk); #1;
            check("max_z_hold_idle", 64'(z), 64'(8'hE1));
        end

        // Zero operand still takes the full iteration count.
        run_op(4'h0, 4'h9, 1'b0, "zero");

        // Start while busy is ignored.
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        pulses = 0;
        for (int cyc = 1; cyc <= 2 * W + 3; cyc++) begin
            if (cyc == 1) begin
                a = 4'd7; b = 4'd7; start = 1'b1;
            end
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (done) begin
                pulses++;
                check("ign_done_cycle", 64'(cyc), 64'(W));
                check("ign_z", 64'(z), 64'(15));
            end
        end
        check("ign_pulses", 64'(pulses), 64'(1));
        check("ign_z_final", 64'(z), 64'(15));

        // Asynchronous reset in the second RUN cycle.
        a = 4'd12; b = 4'd11; start = 1'b1;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        @(posedge clk); #1;          // E1, now in second RUN cycle
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_z", 64'(z), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 2 * W + 2; cyc++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("arst_no_activity", 64'(pulses), 64'(0));
        check("arst_z_after", 64'(z), 64'(0));

        // Back-to-back with start held high: done every W+1 cycles.
        a = 4'd6; b = 4'd7; start = 1'b1;
        @(posedge clk); #1;          // E0
        for (int k = 1; k <= 3 * (W + 1); k++) begin
            @(posedge clk); #1;
            check("b2b_done", 64'(done), 64'((k % (W + 1)) == W));
            if (done) check("b2b_z", 64'(z), 64'(42));
            if (k == 3 * (W + 1) - 1) start = 1'b0;
        end
        check("b2b_busy_end", 64'(busy), 64'(0));

`ifdef MULT_SIGNED_EN
        run_op(4'h8, 4'h8, 1'b1, "s_m8m8");
        run_op(4'hD, 4'h5, 1'b1, "s_m3p5");
        run_op(4'hD, 4'h5, 1'b0, "u_13x5");
        run_op(4'h7, 4'h8, 1'b1, "s_7m8");
`endif

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
`ifdef MULT_SIGNED_EN
            rt = 1'($urandom_range(0, 1));
`else
            rt = 1'b0;
`endif
            run_op(ra, rb, rt, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_seq_n
